mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 30 +++
 rtl/mem_access_ctrl.sv | 116 +++++++++++
 tb/tb_mem_access_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundle of signals between the load/store unit, the access controller and the
// segment array.
interface mem_access_ctrl_if #(
    parameter int NUM_SEG  = 4,
    parameter int SEG_BITS = 2
);
    logic                  REQ_MAC;
    logic                  WR_MAC;
    logic [7+SEG_BITS:0]   ADDR_MAC;
    logic [1:0]            BE_MAC;
    logic [15:0]           WDATA_MAC;
    logic                  ACK_MAC;
    logic [15:0]           RDATA_MAC;
    logic                  BUSY_MAC;
    logic [7:0]            ADDR_SEG;
    logic [15:0]           DATA_IN_SEG;
    logic [NUM_SEG-1:0]    WE_SEG;
    logic [SEG_BITS-1:0]   SEL_SEG;
    logic [15:0]           DATA_OUT_SEG;

    modport slave (
        input  REQ_MAC, WR_MAC, ADDR_MAC, BE_MAC, WDATA_MAC, DATA_OUT_SEG,
        output ACK_MAC, RDATA_MAC, BUSY_MAC, ADDR_SEG, DATA_IN_SEG, WE_SEG, SEL_SEG
    );

    modport master (
        output REQ_MAC, WR_MAC, ADDR_MAC, BE_MAC, WDATA_MAC, DATA_OUT_SEG,
        input  ACK_MAC, RDATA_MAC, BUSY_MAC, ADDR_SEG, DATA_IN_SEG, WE_SEG, SEL_SEG
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences single-word loads, full stores and read-modify-write partial stores
// onto a banked array of 256x16 segments.
//
// state | meaning
// IDLE  | waiting for a request; captures address/data when one arrives
// RD    | segment readback latched into RDATA_MAC
// RMW   | merge store bytes with current word into the write register
// WR    | one-cycle write enable to the selected segment
// DONE  | one-cycle ACK_MAC pulse
module mem_access_ctrl #(
    parameter int NUM_SEG  = 4,
    parameter int SEG_BITS = 2
) (
    input  logic              CLK_MAC,
    input  logic              RST_MAC,
    mem_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RMW  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_q,  state_d;
    logic [7:0]            addr_q,   addr_d;
    logic [SEG_BITS-1:0]   seg_q,    seg_d;
    logic [1:0]            be_q,     be_d;
    logic [15:0]           wdata_q,  wdata_d;
    logic [15:0]           rdata_q,  rdata_d;
    logic [NUM_SEG-1:0]    we_q,     we_d;
    logic                  ack_q,    ack_d;
    logic                  busy_q,   busy_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        seg_d   = seg_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.REQ_MAC) begin
                    addr_d  = bus.ADDR_MAC[7:0];
                    seg_d   = bus.ADDR_MAC[7+SEG_BITS:8];
                    be_d    = bus.BE_MAC;
                    wdata_d = bus.WDATA_MAC;
                    if (!bus.WR_MAC) begin
                        state_d = RD;
                    end else begin
                        case (bus.BE_MAC)
                            2'b11:   state_d = WR;
                            2'b00:   state_d = DONE;
                            default: state_d = RMW;
                        endcase
                    end
                end
            end
            RD: begin
                rdata_d = bus.DATA_OUT_SEG;
                state_d = DONE;
            end
            RMW: begin
                // Disabled bytes keep whatever the segment currently holds
                wdata_d = {be_q[1] ? wdata_q[15:8] : bus.DATA_OUT_SEG[15:8],
                           be_q[0] ? wdata_q[7:0]  : bus.DATA_OUT_SEG[7:0]};
                state_d = WR;
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Enables and ack are decoded from the next state so they leave flops
        we_d   = (state_d == WR) ? (NUM_SEG'(1) << seg_d) : '0;
        ack_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK_MAC) begin
        if (RST_MAC) begin
            state_q <= IDLE;
            addr_q  <= '0;
            seg_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            seg_q   <= seg_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ACK_MAC     = ack_q;
    assign bus.RDATA_MAC   = rdata_q;
    assign bus.BUSY_MAC    = busy_q;
    assign bus.ADDR_SEG    = addr_q;
    assign bus.SEL_SEG     = seg_q;
    assign bus.DATA_IN_SEG = wdata_q;
    assign bus.WE_SEG      = we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a 4x256 segment array, a table of directed
// transactions, and hand-written reset/back-to-back sequences.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.NUM_SEG(4), .SEG_BITS(2)) bus ();

    mem_access_ctrl #(.NUM_SEG(4), .SEG_BITS(2)) dut (
        .CLK_MAC (clk),
        .RST_MAC (rst),
        .bus     (bus)
    );

    logic [15:0] seg_mem [4][256];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 256; w++)
                    seg_mem[s][w] <= 16'h0000;
        end else begin
            for (int s = 0; s < 4; s++)
                if (bus.WE_SEG[s]) seg_mem[s][bus.ADDR_SEG] <= bus.DATA_IN_SEG;
        end
    end

    assign bus.DATA_OUT_SEG = seg_mem[bus.SEL_SEG][bus.ADDR_SEG];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          lat;
        logic [3:0]  we;
        logic [15:0] rdata;
        logic [7:0]  aseg;
    } vec_t;

    vec_t vecs [13];

    // Issues one request from IDLE at a negedge and watches six cycles after it
    task automatic run_txn(input logic wr, input logic [9:0] addr, input logic [1:0] be,
                           input logic [15:0] wd, output int ack_cyc, output int ack_cnt,
                           output logic [3:0] we_seen, output int we_cnt, output int we_cyc,
                           output logic [15:0] rd_at_ack, output logic busy1);
        bus.REQ_MAC   = 1'b1;
        bus.WR_MAC    = wr;
        bus.ADDR_MAC  = addr;
        bus.BE_MAC    = be;
        bus.WDATA_MAC = wd;
        @(posedge clk);
        @(negedge clk);
        bus.REQ_MAC = 1'b0;
        ack_cyc = -1; ack_cnt = 0; we_seen = '0; we_cnt = 0; we_cyc = -1;
        rd_at_ack = 16'hxxxx;
        busy1 = bus.BUSY_MAC;
        for (int k = 1; k <= 6; k++) begin
            if (bus.ACK_MAC) begin
                ack_cnt++;
                if (ack_cyc < 0) begin
                    ack_cyc   = k;
                    rd_at_ack = bus.RDATA_MAC;
                end
            end
            if (bus.WE_SEG != 4'b0000) begin
                we_seen = we_seen | bus.WE_SEG;
                we_cnt++;
                we_cyc = k;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int ack_cyc, ack_cnt, we_cnt, we_cyc;
        logic [3:0]  we_seen;
        logic [15:0] rd;
        logic        busy1;
        int          bad;

        vecs[0]  = '{1'b1, 10'h105, 2'b11, 16'hBEEF, 2, 4'b0010, 16'h0000, 8'h05};
        vecs[1]  = '{1'b0, 10'h105, 2'b00, 16'h0000, 2, 4'b0000, 16'hBEEF, 8'h05};
        vecs[2]  = '{1'b1, 10'h105, 2'b01, 16'h1234, 3, 4'b0010, 16'hBEEF, 8'h05};
        vecs[3]  = '{1'b0, 10'h105, 2'b00, 16'h0000, 2, 4'b0000, 16'hBE34, 8'h05};
        vecs[4]  = '{1'b1, 10'h105, 2'b10, 16'hAA99, 3, 4'b0010, 16'hBE34, 8'h05};
        vecs[5]  = '{1'b0, 10'h105, 2'b00, 16'h0000, 2, 4'b0000, 16'hAA34, 8'h05};
        vecs[6]  = '{1'b1, 10'h3FF, 2'b00, 16'h5555, 1, 4'b0000, 16'hAA34, 8'hFF};
        vecs[7]  = '{1'b0, 10'h3FF, 2'b00, 16'h0000, 2, 4'b0000, 16'h0000, 8'hFF};
        vecs[8]  = '{1'b1, 10'h3FF, 2'b11, 16'h7788, 2, 4'b1000, 16'h0000, 8'hFF};
        vecs[9]  = '{1'b1, 10'h0FF, 2'b11, 16'h1122, 2, 4'b0001, 16'h0000, 8'hFF};
        vecs[10] = '{1'b0, 10'h3FF, 2'b00, 16'h0000, 2, 4'b0000, 16'h7788, 8'hFF};
        vecs[11] = '{1'b0, 10'h0FF, 2'b00, 16'h0000, 2, 4'b0000, 16'h1122, 8'hFF};
        vecs[12] = '{1'b0, 10'h2FF, 2'b00, 16'h0000, 2, 4'b0000, 16'h0000, 8'hFF};

        // Reset asserted together with a pending store: the store must be dropped
        rst = 1'b1; mem_clr = 1'b1;
        bus.REQ_MAC = 1'b1; bus.WR_MAC = 1'b1; bus.ADDR_MAC = 10'h105;
        bus.BE_MAC = 2'b11; bus.WDATA_MAC = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",    32'(bus.ACK_MAC),     32'h0);
        chk("rst_busy",   32'(bus.BUSY_MAC),    32'h0);
        chk("rst_we",     32'(bus.WE_SEG),      32'h0);
        chk("rst_rdata",  32'(bus.RDATA_MAC),   32'h0);
        chk("rst_addr",   32'(bus.ADDR_SEG),    32'h0);
        chk("rst_din",    32'(bus.DATA_IN_SEG), 32'h0);
        chk("rst_sel",    32'(bus.SEL_SEG),     32'h0);
        rst = 1'b0; mem_clr = 1'b0; bus.REQ_MAC = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ACK_MAC || bus.BUSY_MAC || bus.WE_SEG != 4'b0000) bad++;
        end
        chk("rst_req_dropped", 32'(bad), 32'h0);
        chk("rst_mem_untouched", 32'(seg_mem[1][5]), 32'h0);

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                    ack_cyc, ack_cnt, we_seen, we_cnt, we_cyc, rd, busy1);
            chk($sformatf("v%0d_latency", i), 32'(ack_cyc), 32'(vecs[i].lat));
            chk($sformatf("v%0d_ack_pulses", i), 32'(ack_cnt), 32'h1);
            chk($sformatf("v%0d_busy", i), 32'(busy1), 32'h1);
            chk($sformatf("v%0d_we_mask", i), 32'(we_seen), 32'(vecs[i].we));
            chk($sformatf("v%0d_we_count", i), 32'(we_cnt), (vecs[i].we != 4'b0000) ? 32'h1 : 32'h0);
            if (vecs[i].we != 4'b0000)
                chk($sformatf("v%0d_we_cycle", i), 32'(we_cyc), 32'(vecs[i].lat - 1));
            chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].rdata));
            chk($sformatf("v%0d_addr_seg_hold", i), 32'(bus.ADDR_SEG), 32'(vecs[i].aseg));
        end

        // Reset while in RMW: nothing gets written or acknowledged
        bus.REQ_MAC = 1'b1; bus.WR_MAC = 1'b1; bus.ADDR_MAC = 10'h105;
        bus.BE_MAC = 2'b01; bus.WDATA_MAC = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        bus.REQ_MAC = 1'b0;
        chk("rmw_busy_before_rst", 32'(bus.BUSY_MAC), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rmw_rst_idle", 32'(bus.BUSY_MAC), 32'h0);
        chk("rmw_rst_rdata", 32'(bus.RDATA_MAC), 32'h0);
        bad = 0;
        repeat (5) begin
            if (bus.ACK_MAC || bus.WE_SEG != 4'b0000) bad++;
            @(negedge clk);
        end
        chk("rmw_rst_no_ack_we", 32'(bad), 32'h0);
        chk("rmw_rst_word_kept", 32'(seg_mem[1][5]), 32'hAA34);
        run_txn(1'b0, 10'h105, 2'b00, 16'h0000, ack_cyc, ack_cnt, we_seen, we_cnt, we_cyc, rd, busy1);
        chk("rmw_rst_readback", 32'(rd), 32'hAA34);
        chk("rmw_rst_readback_lat", 32'(ack_cyc), 32'h2);

        // REQ held high with the address alternating seg0/seg3 every cycle
        bus.WR_MAC = 1'b0; bus.BE_MAC = 2'b00;
        for (int c = 0; c < 12; c++) begin
            bus.REQ_MAC  = 1'b1;
            bus.ADDR_MAC = (c % 2 == 0) ? 10'h0FF : 10'h3FF;
            chk($sformatf("hold_c%0d_ack", c), 32'(bus.ACK_MAC), (c % 3 == 2) ? 32'h1 : 32'h0);
            if (c % 3 == 2)
                chk($sformatf("hold_c%0d_rdata", c), 32'(bus.RDATA_MAC),
                    (((c - 2) / 3) % 2 == 0) ? 32'h1122 : 32'h7788);
            @(negedge clk);
        end
        bus.REQ_MAC = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
